id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register for the 5-stage RISC-V core; sits directly downstream of the decode control unit and load-use hazard unit.
- Latches decoded control bits, operands, immediate, PC and instruction fields into EX.
- Inserts bubbles on stall or flush.
- Owns the ecall halt sequencer: drains the pipe, then raises is_halted.

---
 rtl/id_ex_pipe_reg.sv | 222 ++++++++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg
//
// ID/EX pipeline register for the 5-stage RISC-V core. It latches the decoded
// control bits, operands, immediate, PC and instruction fields from ID into EX
// with one cycle of latency. It inserts a bubble on flush or load-use stall,
// and while the halt sequencer is draining or halted.
//
// Halt sequencer: an ecall captured into EX with x17 == HALT_CODE moves the FSM
// from RUN to DRAIN. The FSM spends DRAIN_CYCLES cycles letting the older
// instructions retire, then enters HALTED. HALTED is terminal until reset.
//
// Optional feature (macro ID_EX_BUBBLE_CNT_EN):
//   defined   - bubble_count counts flush/stall bubbles inserted in RUN (wraps).
//   undefined - bubble_count is tied to 0 and no counter register exists.
//
// Parameters:
//   HALT_CODE     x17 value that turns an ecall into a halt request
//   DRAIN_CYCLES  cycles from the ecall entering EX until is_halted
//   XLEN          datapath width
//
// Ports:
//   clk, reset               clock; asynchronous active-high reset
//   id_* control bits        decoded control from ID
//   id_is_stall, flush       load-use stall / control-flow redirect (bubble)
//   id_pc, id_rs1_data, id_rs2_data, id_imm, id_x17_data, id_inst  ID data
//   ex_* control bits        registered control (0 in a bubble)
//   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  registered data (held in a bubble)
//   ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7  instruction fields
//   ex_valid                 1 = real instruction in EX, 0 = bubble
//   hold_fetch               high while draining or halted
//   is_halted                halt sequence complete
//   bubble_count             flush/stall bubble statistic
// -----------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int HALT_CODE    = 10,
    parameter int DRAIN_CYCLES = 3,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            id_mem_read,
    input  logic            id_mem_to_reg,
    input  logic            id_mem_write,
    input  logic            id_alu_src,
    input  logic            id_write_enable,
    input  logic            id_pc_to_reg,
    input  logic            id_alu_op,
    input  logic            id_is_ecall,
    input  logic            id_is_stall,
    input  logic            flush,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_x17_data,
    input  logic [31:0]     id_inst,

    output logic            ex_mem_read,
    output logic            ex_mem_to_reg,
    output logic            ex_mem_write,
    output logic            ex_alu_src,
    output logic            ex_write_enable,
    output logic            ex_pc_to_reg,
    output logic            ex_alu_op,
    output logic            ex_is_ecall,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic            ex_valid,
    output logic            hold_fetch,
    output logic            is_halted,
    output logic [31:0]     bubble_count
);

    localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] drain_cnt, drain_cnt_nxt;
    logic             capture;
    logic             halt_req;
    logic             stall_bubble;

    // The opcode field is not forwarded; decode has already consumed it.
    logic unused_opcode;
    assign unused_opcode = ^id_inst[6:0];

    // Only RUN ever latches a real instruction; DRAIN and HALTED force bubbles.
    assign capture      = (state == ST_RUN) && !flush && !id_is_stall;
    assign halt_req     = capture && id_is_ecall && (id_x17_data == XLEN'(HALT_CODE));
    assign stall_bubble = (state == ST_RUN) && (flush || id_is_stall);

    assign hold_fetch = (state != ST_RUN);
    assign is_halted  = (state == ST_HALTED);

    // ---- halt sequencer: next state --------------------------------------
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        unique case (state)
            ST_RUN: begin
                if (halt_req) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                // The counter equals the number of edges since the ecall edge.
                if (drain_cnt == CNT_W'(DRAIN_CYCLES)) begin
                    state_nxt = ST_HALTED;
                end else begin
                    drain_cnt_nxt = drain_cnt + CNT_W'(1);
                end
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt     = ST_RUN;
                drain_cnt_nxt = '0;
            end
        endcase
    end

    // ---- halt sequencer: state register ----------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // ---- ID -> EX stage boundary -----------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_mem_read     <= 1'b0;
            ex_mem_to_reg   <= 1'b0;
            ex_mem_write    <= 1'b0;
            ex_alu_src      <= 1'b0;
            ex_write_enable <= 1'b0;
            ex_pc_to_reg    <= 1'b0;
            ex_alu_op       <= 1'b0;
            ex_is_ecall     <= 1'b0;
            ex_valid        <= 1'b0;
            ex_pc           <= '0;
            ex_rs1_data     <= '0;
            ex_rs2_data     <= '0;
            ex_imm          <= '0;
            ex_rs1          <= '0;
            ex_rs2          <= '0;
            ex_rd           <= '0;
            ex_funct3       <= '0;
            ex_funct7       <= '0;
        end else if (capture) begin
            ex_mem_read     <= id_mem_read;
            ex_mem_to_reg   <= id_mem_to_reg;
            ex_mem_write    <= id_mem_write;
            ex_alu_src      <= id_alu_src;
            ex_write_enable <= id_write_enable;
            ex_pc_to_reg    <= id_pc_to_reg;
            ex_alu_op       <= id_alu_op;
            ex_is_ecall     <= id_is_ecall;
            ex_valid        <= 1'b1;
            ex_pc           <= id_pc;
            ex_rs1_data     <= id_rs1_data;
            ex_rs2_data     <= id_rs2_data;
            ex_imm          <= id_imm;
            ex_rs1          <= id_inst[19:15];
            ex_rs2          <= id_inst[24:20];
            ex_rd           <= id_inst[11:7];
            ex_funct3       <= id_inst[14:12];
            ex_funct7       <= id_inst[31:25];
        end else begin
            // Bubble: kill control, keep data/fields from the last capture.
            ex_mem_read     <= 1'b0;
            ex_mem_to_reg   <= 1'b0;
            ex_mem_write    <= 1'b0;
            ex_alu_src      <= 1'b0;
            ex_write_enable <= 1'b0;
            ex_pc_to_reg    <= 1'b0;
            ex_alu_op       <= 1'b0;
            ex_is_ecall     <= 1'b0;
            ex_valid        <= 1'b0;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q;

    // Stall and flush together are one bubble, so they count once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else if (stall_bubble) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign bubble_count = bubble_cnt_q;
`else
    logic unused_stall_bubble;
    assign unused_stall_bubble = stall_bubble;
    assign bubble_count        = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

    localparam int XLEN         = 32;
    localparam int HALT_CODE    = 10;
    localparam int DRAIN_CYCLES = 3;

    logic        clk = 1'b0;
    logic        reset;
    // {mem_read, mem_to_reg, mem_write, alu_src, write_enable, pc_to_reg, alu_op, is_ecall}
    logic [7:0]  id_ctrl;
    logic        id_is_stall, flush;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, id_x17_data, id_inst;

    logic ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src;
    logic ex_write_enable, ex_pc_to_reg, ex_alu_op, ex_is_ecall;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        ex_valid, hold_fetch, is_halted;
    logic [31:0] bubble_count;
    logic [7:0]  ex_ctrl;

    assign ex_ctrl = {ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src,
                      ex_write_enable, ex_pc_to_reg, ex_alu_op, ex_is_ecall};

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.HALT_CODE(HALT_CODE), .DRAIN_CYCLES(DRAIN_CYCLES), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .id_mem_read(id_ctrl[7]), .id_mem_to_reg(id_ctrl[6]), .id_mem_write(id_ctrl[5]),
        .id_alu_src(id_ctrl[4]), .id_write_enable(id_ctrl[3]), .id_pc_to_reg(id_ctrl[2]),
        .id_alu_op(id_ctrl[1]), .id_is_ecall(id_ctrl[0]),
        .id_is_stall(id_is_stall), .flush(flush),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_x17_data(id_x17_data), .id_inst(id_inst),
        .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_write_enable(ex_write_enable), .ex_pc_to_reg(ex_pc_to_reg),
        .ex_alu_op(ex_alu_op), .ex_is_ecall(ex_is_ecall),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7(ex_funct7), .ex_valid(ex_valid), .hold_fetch(hold_fetch),
        .is_halted(is_halted), .bubble_count(bubble_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the expected EX contents, plus the edge index at which a
    // halting ecall was captured (-1 = none). Halt status follows from age.
    logic [7:0]  m_ctrl;
    logic        m_valid;
    logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm, m_inst, m_bub;
    int          edge_n;
    int          ecall_edge;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_hold();
        return ecall_edge >= 0;
    endfunction

    function automatic bit m_halted();
        return (ecall_edge >= 0) && (edge_n - ecall_edge >= DRAIN_CYCLES);
    endfunction

    task automatic model_clear();
        m_ctrl = '0; m_valid = 1'b0;
        m_pc = '0; m_rs1d = '0; m_rs2d = '0; m_imm = '0; m_inst = '0; m_bub = '0;
        ecall_edge = -1;
    endtask

    task automatic model_edge();
        bit running;
        running = (ecall_edge < 0);
        edge_n++;
        if (running && !flush && !id_is_stall) begin
            m_ctrl = id_ctrl; m_valid = 1'b1;
            m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data;
            m_imm = id_imm; m_inst = id_inst;
            if (id_ctrl[0] && id_x17_data == 32'(HALT_CODE)) ecall_edge = edge_n;
        end else begin
            m_ctrl = '0; m_valid = 1'b0;
        end
        if (running && (flush || id_is_stall)) m_bub = m_bub + 32'd1;
    endtask

    task automatic check_all();
        chk("ctrl", 32'(ex_ctrl), 32'(m_ctrl));
        chk("valid", 32'(ex_valid), 32'(m_valid));
        chk("pc", ex_pc, m_pc);
        chk("rs1_data", ex_rs1_data, m_rs1d);
        chk("rs2_data", ex_rs2_data, m_rs2d);
        chk("imm", ex_imm, m_imm);
        chk("fields", {ex_funct7, ex_rs2, ex_rs1, ex_funct3, ex_rd, 7'd0},
            {m_inst[31:7], 7'd0});
        chk("hold_fetch", 32'(hold_fetch), 32'(m_hold()));
        chk("is_halted", 32'(is_halted), 32'(m_halted()));
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("bubble_count", bubble_count, m_bub);
`else
        chk("bubble_count", bubble_count, 32'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive_idle();
        id_ctrl = '0; id_is_stall = 1'b0; flush = 1'b0;
        id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_x17_data = '0; id_inst = '0;
    endtask

    task automatic drive_rand();
        id_ctrl     = 8'($urandom);
        id_is_stall = ($urandom_range(0, 4) == 0);
        flush       = ($urandom_range(0, 5) == 0);
        id_pc       = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
        id_imm      = $urandom; id_inst = $urandom;
        id_x17_data = ($urandom_range(0, 5) == 0) ? 32'(HALT_CODE) : 32'($urandom_range(0, 15));
    endtask

    // Asynchronous reset: checked mid-cycle, then across one held edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_clear();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        edge_n = 0;
        reset  = 1'b0;
        drive_idle();
        model_clear();
        #2;
        do_reset();

        // Reset mid-drain
        id_ctrl = 8'h01; id_x17_data = 32'(HALT_CODE);
        step();
        chk("drain_hold", 32'(hold_fetch), 32'd1);
        drive_idle();
        step();
        #2;
        do_reset();
        chk("rst_halted", 32'(is_halted), 32'd0);
        chk("rst_hold", 32'(hold_fetch), 32'd0);

        // Normal capture: add x10,x10,x11
        id_ctrl = 8'h08; id_pc = 32'h40; id_inst = 32'h00B5_0533;
        step();
        chk("cap_pc", ex_pc, 32'h40);
        chk("cap_rd", 32'(ex_rd), 32'd10);
        chk("cap_rs1", 32'(ex_rs1), 32'd10);
        chk("cap_rs2", 32'(ex_rs2), 32'd11);
        chk("cap_valid", 32'(ex_valid), 32'd1);
        chk("cap_we", 32'(ex_write_enable), 32'd1);

        // Load-use stall
        id_ctrl = 8'h20; id_is_stall = 1'b1;
        step();
        chk("stall_mw", 32'(ex_mem_write), 32'd0);
        chk("stall_valid", 32'(ex_valid), 32'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("stall_cnt", bubble_count, 32'd1);
`else
        chk("stall_cnt", bubble_count, 32'd0);
`endif

        // Flush kills a halting ecall; stall+flush also counted once
        drive_idle();
        id_ctrl = 8'h01; id_x17_data = 32'(HALT_CODE); flush = 1'b1; id_is_stall = 1'b1;
        step();
        chk("flush_ecall", 32'(ex_is_ecall), 32'd0);
        drive_idle();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("flush_nohalt", 32'(is_halted), 32'd0);
        end

        // Non-halting ecall passes through
        id_ctrl = 8'h01; id_x17_data = 32'd5;
        step();
        chk("ecall5", 32'(ex_is_ecall), 32'd1);
        chk("ecall5_hold", 32'(hold_fetch), 32'd0);

        // Halting ecall at edge T
        id_x17_data = 32'(HALT_CODE); id_pc = 32'h80;
        step();
        chk("halt_T_hold", 32'(hold_fetch), 32'd1);
        id_ctrl = 8'hFE; id_pc = 32'h84;
        step();
        step();
        chk("halt_T2", 32'(is_halted), 32'd0);
        step();
        chk("halt_T3", 32'(is_halted), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halted_bubble", 32'(ex_valid), 32'd0);
        end
        flush = 1'b1;
        step();
        chk("halted_flush", 32'(is_halted), 32'd1);
        drive_idle();
        #2;
        do_reset();

`ifdef ID_EX_BUBBLE_CNT_EN
        // Counter wrap
        force dut.bubble_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_cnt_q;
        m_bub = 32'hFFFF_FFFF;
        #1;
        chk("wrap_pre", bubble_count, 32'hFFFF_FFFF);
        id_is_stall = 1'b1;
        step();
        chk("wrap", bubble_count, 32'd0);
        drive_idle();
`endif

        // Randomized run against the model
        for (int i = 0; i < 800; i++) begin
            drive_rand();
            step();
            if ((m_halted() && $urandom_range(0, 3) == 0) || $urandom_range(0, 150) == 0) begin
                drive_rand();
                #2;
                do_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
